// File: rtl/btc_link_pkg.sv
// Shared definitions for the host-side miner link.
// Contents: header/hash sizes, bit positions of the miner uo/ui pins,
// the link state enum and small state-classification helpers.
package btc_link_pkg;

    localparam int HDR_WORDS   = 40;
    localparam int HASH_BYTES  = 32;

    // Miner uo pin layout
    localparam int UO_RQ_BIT   = 7;
    localparam int UO_DONE_BIT = 6;
    localparam int UO_ADDR_MSB = 5;
    localparam int UO_ADDR_LSB = 0;

    // Miner ui pin layout during readout
    localparam int UI_ACK_BIT  = 7;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RESET_HOLD = 3'd1,
        ST_LOAD       = 3'd2,
        ST_COMPUTE    = 3'd3,
        ST_READOUT    = 3'd4,
        ST_DONE       = 3'd5,
        ST_ERROR      = 3'd6
    } link_state_e;

    // States in which the host may write the header and launch a job
    function automatic logic is_quiescent(input link_state_e s);
        return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERROR);
    endfunction

    // States in which the watchdog runs
    function automatic logic is_active(input link_state_e s);
        return (s == ST_RESET_HOLD) || (s == ST_LOAD) ||
               (s == ST_COMPUTE)    || (s == ST_READOUT);
    endfunction

    // Miner is out of reset while a job runs and while it idles in DONE
    function automatic logic chip_released(input link_state_e s);
        return (s == ST_LOAD) || (s == ST_COMPUTE) ||
               (s == ST_READOUT) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/btc_host_link_if.sv
// Pin bundle between the host link controller and the miner tile.
//   chip_rst_n   : miner reset (host -> miner)
//   chip_ui      : miner ui pins (host -> miner)
//   chip_uio_out : host drive value for the shared uio pins
//   chip_uio_oe  : host owns the uio pins when high
//   chip_uo      : miner uo pins (rq / done / addr)
//   chip_uio_in  : miner drive value on the uio pins (hash byte)
// master = host side, slave = miner side.
interface btc_host_link_if;
    logic       chip_rst_n;
    logic [7:0] chip_ui;
    logic [7:0] chip_uio_out;
    logic       chip_uio_oe;
    logic [7:0] chip_uo;
    logic [7:0] chip_uio_in;

    modport master (
        output chip_rst_n, chip_ui, chip_uio_out, chip_uio_oe,
        input  chip_uo, chip_uio_in
    );

    modport slave (
        input  chip_rst_n, chip_ui, chip_uio_out, chip_uio_oe,
        output chip_uo, chip_uio_in
    );
endinterface

// File: rtl/btc_hdr_ram.sv
// 40 x 16 block-header buffer.
//   clk     : write clock
//   we_i    : write strobe (indices of 40 and above are dropped)
//   waddr_i : write word index
//   wdata_i : write word
//   raddr_i : asynchronous read index (reads 0 at 40 and above)
//   rdata_o : read word
// Contents are not reset; they are undefined until written.
module btc_hdr_ram
    import btc_link_pkg::*;
(
    input  logic        clk,
    input  logic        we_i,
    input  logic [5:0]  waddr_i,
    input  logic [15:0] wdata_i,
    input  logic [5:0]  raddr_i,
    output logic [15:0] rdata_o
);

    logic [15:0] mem_q [0:HDR_WORDS-1];

    // Synchronous write port
    always_ff @(posedge clk) begin
        if (we_i && (waddr_i < 6'(HDR_WORDS))) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Asynchronous read port, zero outside the header range
    always_comb begin
        if (raddr_i < 6'(HDR_WORDS)) begin
            rdata_o = mem_q[raddr_i];
        end else begin
            rdata_o = 16'h0000;
        end
    end

endmodule

// File: rtl/btc_host_link.sv
// Host-side controller for the SHA-256 miner tile pin protocol.
// Buffers a 640-bit header, holds the miner in reset at job start, serves
// the miner's word requests, waits for done and reads back 32 hash bytes
// with a one-cycle ack per byte. A watchdog aborts stalled jobs.
//   clk, rst_n           : clock shared with the miner, async active-low reset
//   hdr_we/waddr/wdata   : header buffer write port (quiescent states only)
//   start                : single-cycle job request
//   busy                 : job in flight
//   hash_out, hash_valid : captured hash and its completion pulse
//   timeout_err          : sticky watchdog flag, cleared by an accepted start
//   chip                 : miner pin bundle (master side)
module btc_host_link
    import btc_link_pkg::*;
#(
    parameter int CHIP_RST_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 65535
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           hdr_we,
    input  logic [5:0]     hdr_waddr,
    input  logic [15:0]    hdr_wdata,
    input  logic           start,
    output logic           busy,
    output logic [255:0]   hash_out,
    output logic           hash_valid,
    output logic           timeout_err,
    btc_host_link_if.master chip
);

    localparam int RCW = (CHIP_RST_CYCLES > 1) ? $clog2(CHIP_RST_CYCLES + 1) : 1;
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [5:0] ADDR_END = 6'(HDR_WORDS);
    localparam logic [5:0] K_END    = 6'(HASH_BYTES);

    link_state_e    state_q, state_d;
    logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
    logic [WDW-1:0] wdog_q, wdog_d;
    logic [5:0]     k_q, k_d;
    logic           ack_q, ack_d, ack_prev_q, rq_prev_q;
    logic           busy_q, busy_d;
    logic           crst_n_q, crst_n_d;
    logic           oe_q, oe_d;
    logic           hv_q, hv_d;
    logic           terr_q, terr_d;
    logic [7:0]     ui_q, ui_d;
    logic [7:0]     uio_q, uio_d;
    logic [255:0]   hash_q, hash_d;

    logic [15:0]    rd_data_s;
    logic [5:0]     addr_s;
    logic           rq_s, done_s, quiet_s;
    logic           wdog_exp_s, wdog_clr_s, rst_done_s, capture_s, hdr_wr_s;

    assign addr_s     = chip.chip_uo[UO_ADDR_MSB:UO_ADDR_LSB];
    assign rq_s       = chip.chip_uo[UO_RQ_BIT];
    assign done_s     = chip.chip_uo[UO_DONE_BIT];
    assign quiet_s    = is_quiescent(state_q);
    assign hdr_wr_s   = hdr_we && quiet_s;
    assign rst_done_s = (rst_cnt_q == RCW'(CHIP_RST_CYCLES - 1));
    assign wdog_exp_s = is_active(state_q) && (wdog_q == WDW'(TIMEOUT_CYCLES - 1));
    // Accept a byte only when the previous ack has fully cleared for a cycle,
    // giving the miner time to drop rq and present the next byte.
    assign capture_s  = (state_q == ST_READOUT) && rq_s && !ack_q && !ack_prev_q &&
                        (k_q < K_END);
    // Progress events that keep the watchdog alive
    assign wdog_clr_s = ((state_q == ST_LOAD) && rq_prev_q && !rq_s) || capture_s;

    btc_hdr_ram u_ram (
        .clk     (clk),
        .we_i    (hdr_wr_s),
        .waddr_i (hdr_waddr),
        .wdata_i (hdr_wdata),
        .raddr_i (addr_s),
        .rdata_o (rd_data_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; watchdog expiry overrides any other transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) state_d = ST_RESET_HOLD;
                else       state_d = state_q;
            end
            ST_RESET_HOLD: begin
                if (wdog_exp_s)      state_d = ST_ERROR;
                else if (rst_done_s) state_d = ST_LOAD;
                else                 state_d = state_q;
            end
            ST_LOAD: begin
                if (wdog_exp_s)              state_d = ST_ERROR;
                else if (addr_s == ADDR_END) state_d = ST_COMPUTE;
                else                         state_d = state_q;
            end
            ST_COMPUTE: begin
                if (wdog_exp_s)  state_d = ST_ERROR;
                else if (done_s) state_d = ST_READOUT;
                else             state_d = state_q;
            end
            ST_READOUT: begin
                if (wdog_exp_s)          state_d = ST_ERROR;
                else if (k_q == K_END)   state_d = ST_DONE;
                else                     state_d = state_q;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values, all derived from the upcoming state
    always_comb begin
        busy_d   = !is_quiescent(state_d);
        crst_n_d = chip_released(state_d);
        oe_d     = (state_d == ST_LOAD);
        hv_d     = (state_q == ST_READOUT) && (state_d == ST_DONE);
        ack_d    = capture_s;

        if (state_q == ST_RESET_HOLD) rst_cnt_d = rst_cnt_q + 1'b1;
        else                          rst_cnt_d = '0;

        if ((state_d != state_q) || !is_active(state_q) || wdog_clr_s) wdog_d = '0;
        else                                                           wdog_d = wdog_q + 1'b1;

        if (state_q != ST_READOUT) k_d = 6'd0;
        else if (capture_s)        k_d = k_q + 6'd1;
        else                       k_d = k_q;

        // Byte k lands at bits [255-8k -: 8]; ~k[4:0] is 31-k
        hash_d = hash_q;
        if (capture_s) hash_d[{~k_q[4:0], 3'b000} +: 8] = chip.chip_uio_in;
        else           hash_d = hash_q;

        case (state_d)
            ST_LOAD: begin
                ui_d  = rd_data_s[15:8];
                uio_d = rd_data_s[7:0];
            end
            ST_READOUT: begin
                ui_d  = {ack_d, 7'b000_0000};
                uio_d = 8'h00;
            end
            default: begin
                ui_d  = 8'h00;
                uio_d = 8'h00;
            end
        endcase

        if (state_d == ST_ERROR)    terr_d = 1'b1;
        else if (quiet_s && start)  terr_d = 1'b0;
        else                        terr_d = terr_q;
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_cnt_q  <= '0;
            wdog_q     <= '0;
            k_q        <= 6'd0;
            ack_q      <= 1'b0;
            ack_prev_q <= 1'b0;
            rq_prev_q  <= 1'b0;
            busy_q     <= 1'b0;
            crst_n_q   <= 1'b0;
            oe_q       <= 1'b0;
            hv_q       <= 1'b0;
            terr_q     <= 1'b0;
            ui_q       <= 8'h00;
            uio_q      <= 8'h00;
            hash_q     <= 256'h0;
        end else begin
            rst_cnt_q  <= rst_cnt_d;
            wdog_q     <= wdog_d;
            k_q        <= k_d;
            ack_q      <= ack_d;
            ack_prev_q <= ack_q;
            rq_prev_q  <= rq_s;
            busy_q     <= busy_d;
            crst_n_q   <= crst_n_d;
            oe_q       <= oe_d;
            hv_q       <= hv_d;
            terr_q     <= terr_d;
            ui_q       <= ui_d;
            uio_q      <= uio_d;
            hash_q     <= hash_d;
        end
    end

    assign busy              = busy_q;
    assign hash_out          = hash_q;
    assign hash_valid        = hv_q;
    assign timeout_err       = terr_q;
    assign chip.chip_rst_n   = crst_n_q;
    assign chip.chip_ui      = ui_q;
    assign chip.chip_uio_out = uio_q;
    assign chip.chip_uio_oe  = oe_q;

endmodule

// File: tb/tb_btc_host_link.sv
// Self-checking bench for btc_host_link: a behavioural miner drives the pin
// protocol; expectations come from the header shadow and hash byte tables.
module tb_btc_host_link;
    import btc_link_pkg::*;

    localparam int C_RST = 4;
    localparam int T_OUT = 100;
    localparam int LOAD_CYCLES = 81; // rst release edge .. addr 40 seen (2 cycles/word + 1)

    logic         clk;
    logic         rst_n;
    logic         hdr_we;
    logic [5:0]   hdr_waddr;
    logic [15:0]  hdr_wdata;
    logic         start;
    logic         busy;
    logic [255:0] hash_out;
    logic         hash_valid;
    logic         timeout_err;

    btc_host_link_if ifc ();

    btc_host_link #(.CHIP_RST_CYCLES(C_RST), .TIMEOUT_CYCLES(T_OUT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hdr_we      (hdr_we),
        .hdr_waddr   (hdr_waddr),
        .hdr_wdata   (hdr_wdata),
        .start       (start),
        .busy        (busy),
        .hash_out    (hash_out),
        .hash_valid  (hash_valid),
        .timeout_err (timeout_err),
        .chip        (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference data
    logic [15:0] shadow [40];
    logic [7:0]  hbytes [32];

    function automatic logic [255:0] exp_hash();
        logic [255:0] h;
        h = '0;
        for (int i = 0; i < 32; i++) h = {h[247:0], hbytes[i]};
        return h;
    endfunction

    // Miner model state
    int          m_phase = 0;  // 0 reset, 1 load, 2 compute, 3 readout, 4 done-idle
    int          m_w, m_step, m_cnt, m_b, m_sub;
    int          m_delay = 10;
    bit          never_done = 0;
    logic [15:0] m_block [40];
    int          acks = 0, ack_wide = 0, last_ack = 0, t40 = 0;

    initial begin
        ifc.chip_uo = 8'h00;
        ifc.chip_uio_in = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (ifc.chip_rst_n !== 1'b1) begin
                m_phase = 0;
                ifc.chip_uo = 8'h00;
                ifc.chip_uio_in = 8'h00;
            end else begin
                case (m_phase)
                    0: begin
                        m_w = 0; m_step = 1; m_phase = 1;
                        ifc.chip_uo = 8'h00;
                    end
                    1: begin
                        if (m_step == 1) begin
                            m_block[m_w] = {ifc.chip_ui, ifc.chip_uio_out};
                            ifc.chip_uo = {2'b10, 6'(m_w)};
                            m_step = 0;
                        end else begin
                            m_w++;
                            ifc.chip_uo = {2'b00, 6'(m_w)};
                            if (m_w == 40) begin
                                m_phase = 2; m_cnt = 0; t40 = cyc;
                            end else m_step = 1;
                        end
                    end
                    2: begin
                        m_cnt++;
                        if (!never_done && m_cnt >= m_delay) begin
                            ifc.chip_uo = {2'b01, 6'd40};
                            m_phase = 3; m_b = 0; m_sub = 0;
                        end
                    end
                    3: begin
                        if (m_sub == 0) begin
                            ifc.chip_uio_in = hbytes[m_b];
                            ifc.chip_uo = {2'b11, 6'd40};
                            m_sub = 1;
                        end else if (m_sub == 1) begin
                            if (ifc.chip_ui[UI_ACK_BIT]) begin
                                acks++; last_ack = cyc; m_b++;
                                ifc.chip_uo = {2'b01, 6'd40};
                                m_sub = 2;
                            end
                        end else begin
                            if (ifc.chip_ui[UI_ACK_BIT]) ack_wide++;
                            if (m_b == 32) m_phase = 4;
                            else begin
                                ifc.chip_uio_in = hbytes[m_b];
                                ifc.chip_uo = {2'b11, 6'd40};
                                m_sub = 1;
                            end
                        end
                    end
                    default: ifc.chip_uo = {2'b01, 6'd40};
                endcase
            end
        end
    end

    // Output monitor
    int hv_cnt = 0, hv_cyc = 0, hv_wide = 0, oe_cycles = 0;
    bit hv_prev = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (hash_valid === 1'b1) begin
                hv_cnt++; hv_cyc = cyc;
                if (hv_prev) hv_wide++;
            end
            hv_prev = (hash_valid === 1'b1);
            if (ifc.chip_uio_oe === 1'b1) oe_cycles++;
        end
    end

    int hv_base;

    task automatic write_word(input int a, input logic [15:0] d, input bit accepted);
        hdr_we = 1'b1; hdr_waddr = 6'(a); hdr_wdata = d;
        @(negedge clk);
        hdr_we = 1'b0;
        if (accepted) shadow[a] = d;
    endtask

    task automatic random_job_data();
        for (int i = 0; i < 40; i++) write_word(i, 16'($urandom), 1'b1);
        for (int i = 0; i < 32; i++) hbytes[i] = 8'($urandom);
    endtask

    task automatic start_job(input bit wr, input int a, input logic [15:0] d,
                             input int delay, input bit nd);
        int lowc;
        acks = 0; ack_wide = 0; oe_cycles = 0; hv_base = hv_cnt;
        m_delay = delay; never_done = nd;
        start = 1'b1;
        if (wr) begin
            hdr_we = 1'b1; hdr_waddr = 6'(a); hdr_wdata = d; shadow[a] = d;
        end
        @(negedge clk);
        start = 1'b0; hdr_we = 1'b0;
        chk("busy_after_start", 256'(busy), 256'(1));
        chk("terr_clear_on_start", 256'(timeout_err), 256'(0));
        lowc = 0;
        for (int i = 0; i < 20 && ifc.chip_rst_n !== 1'b1; i++) begin
            lowc++;
            @(negedge clk);
        end
        chk("chip_rst_low_cycles", 256'(lowc), 256'(C_RST));
    endtask

    task automatic finish_job(input bit check_block);
        int n;
        n = 0;
        while (hv_cnt == hv_base && n < 2000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("hash_valid_pulses", 256'(hv_cnt - hv_base), 256'(1));
        chk("hash_valid_width", 256'(hv_wide), 256'(0));
        chk("hash_out", hash_out, exp_hash());
        chk("ack_count", 256'(acks), 256'(32));
        chk("ack_width", 256'(ack_wide), 256'(0));
        chk("hv_after_last_ack", 256'(hv_cyc - last_ack), 256'(1));
        chk("oe_cycles_load_only", 256'(oe_cycles), 256'(LOAD_CYCLES));
        chk("busy_in_done", 256'(busy), 256'(0));
        chk("chip_rst_in_done", 256'(ifc.chip_rst_n), 256'(1));
        chk("terr_in_done", 256'(timeout_err), 256'(0));
        if (check_block)
            for (int w = 0; w < 40; w++) chk("hdr_word", 256'(m_block[w]), 256'(shadow[w]));
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_hash_valid", 256'(hash_valid), 256'(0));
        chk("rst_timeout_err", 256'(timeout_err), 256'(0));
        chk("rst_chip_rst_n", 256'(ifc.chip_rst_n), 256'(0));
        chk("rst_uio_oe", 256'(ifc.chip_uio_oe), 256'(0));
        chk("rst_chip_ui", 256'(ifc.chip_ui), 256'(0));
        chk("rst_uio_out", 256'(ifc.chip_uio_out), 256'(0));
        chk("rst_hash_out", hash_out, 256'(0));
    endtask

    initial begin
        int n;
        logic [15:0] w5_new, w7_new;
        rst_n = 1'b0; hdr_we = 1'b0; hdr_waddr = 6'd0; hdr_wdata = 16'h0; start = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // Job 1: fixed header pattern and ascending hash bytes
        for (int k = 0; k < 40; k++) write_word(k, {8'(k), 8'hA5}, 1'b1);
        for (int i = 0; i < 32; i++) hbytes[i] = 8'(i);
        start_job(1'b0, 0, 16'h0, 10, 1'b0);
        finish_job(1'b1);
        chk("hash_ascending", hash_out, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);

        // Job 2 from DONE: write and start during COMPUTE must be dropped
        random_job_data();
        start_job(1'b0, 0, 16'h0, 40, 1'b0);
        n = 0;
        while (m_phase != 2 && n < 500) begin @(negedge clk); n++; end
        chk("reach_compute", 256'(m_phase), 256'(2));
        w5_new = ~shadow[5];
        write_word(5, w5_new, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_mid_job", 256'(busy), 256'(1));
        chk("chip_rst_mid_job", 256'(ifc.chip_rst_n), 256'(1));
        finish_job(1'b1);

        // Job 3: same-cycle write of word 7 with start; word 5 stays original
        for (int i = 0; i < 32; i++) hbytes[i] = 8'($urandom);
        w7_new = 16'($urandom);
        start_job(1'b1, 7, w7_new, 3 + int'($urandom_range(0, 50)), 1'b0);
        finish_job(1'b1);

        // Job 4: host reset in the middle of readout
        for (int i = 0; i < 32; i++) hbytes[i] = 8'($urandom);
        start_job(1'b0, 0, 16'h0, 5, 1'b0);
        n = 0;
        while (acks < 10 && n < 2000) begin @(negedge clk); n++; end
        chk("reach_byte10", 256'(acks), 256'(10));
        hv_base = hv_cnt;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("no_hv_after_reset", 256'(hv_cnt - hv_base), 256'(0));
        chk("idle_after_reset", 256'(busy), 256'(0));

        // Job 5: miner never finishes, watchdog fires
        random_job_data();
        start_job(1'b0, 0, 16'h0, 10, 1'b1);
        n = 0;
        while (timeout_err !== 1'b1 && n < 1000) begin @(negedge clk); n++; end
        chk("timeout_err_set", 256'(timeout_err), 256'(1));
        chk("timeout_latency", 256'(cyc - t40), 256'(1 + T_OUT));
        chk("timeout_chip_rst", 256'(ifc.chip_rst_n), 256'(0));
        chk("timeout_busy", 256'(busy), 256'(0));
        chk("timeout_oe", 256'(ifc.chip_uio_oe), 256'(0));

        // Job 6: recovery from ERROR with a fresh header
        random_job_data();
        start_job(1'b0, 0, 16'h0, 3 + int'($urandom_range(0, 50)), 1'b0);
        finish_job(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
